// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/func constants, state encoding and datapath select encodings
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRC2_RT   = 2'b00;
    localparam logic [1:0] SRC2_FOUR = 2'b01;
    localparam logic [1:0] SRC2_IMM  = 2'b10;
    localparam logic [1:0] SRC2_IMM2 = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: maps opcode/func to an ALU operation and flags unsupported instructions
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic [2:0] alu_ctrl_o,
    output logic       legal_o
);

    // R-type selects on func, everything else on opcode; memory/branch/jump fall back to add
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        if (opcode_i == OP_R) begin
            case (func_i)
                F_ADD, F_JR: alu_ctrl_o = ALU_ADD;
                F_SUB:       alu_ctrl_o = ALU_SUB;
                F_AND:       alu_ctrl_o = ALU_AND;
                F_OR:        alu_ctrl_o = ALU_OR;
                F_SLT:       alu_ctrl_o = ALU_SLT;
                F_SLL:       alu_ctrl_o = ALU_SLL;
                F_SRL:       alu_ctrl_o = ALU_SRL;
                default:     legal_o    = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_ANDI: alu_ctrl_o = ALU_AND;
                OP_ORI:  alu_ctrl_o = ALU_OR;
                OP_SLTI: alu_ctrl_o = ALU_SLT;
                OP_LUI:  alu_ctrl_o = ALU_LUI;
                OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: alu_ctrl_o = ALU_ADD;
                default: legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM sequencing a shared memory/ALU datapath
// Define MULTICYCLE_CTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_HS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [2:0] ALUControl,
    output logic [1:0] RegDst,
    output logic [1:0] Mem2Reg,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e     state_q, state_d;
    logic       illegal_q;
    logic [2:0] dec_alu;
    logic       dec_legal;
    logic       mem_ok;

    mc_alu_dec u_dec (
        .opcode_i   (opcode),
        .func_i     (func),
        .alu_ctrl_o (dec_alu),
        .legal_o    (dec_legal)
    );

    assign mem_ok  = !MEM_HS || mem_ready;
    assign illegal = illegal_q;
    assign state   = state_q;

    // next-state: memory states wait on the handshake, DECODE dispatches by instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:              state_d = S_FETCH;
            S_FETCH:            state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE:           state_d = !dec_legal ? S_HALT
                                        : opcode == OP_R ? (func == F_JR ? S_JUMP : S_EXEC_R)
                                        : (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR
                                        : (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH
                                        : (opcode == OP_J || opcode == OP_JAL) ? S_JUMP
                                        : S_EXEC_I;
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR:         state_d = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:           state_d = mem_ok ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:           state_d = mem_ok ? S_FETCH : S_MEM_WR;
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:             state_d = S_HALT;
            default:            state_d = S_RST;
        endcase
    end

    // state register plus the sticky illegal flag raised when DECODE rejects an instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_q == S_DECODE && !dec_legal);
        end
    end

    // Moore decode of the datapath controls; only FETCH strobes and BRANCH PCWrite see inputs
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = PC_ALU;
        ALUSrc1    = 1'b0;
        ALUSrc2    = SRC2_RT;
        ALUControl = ALU_AND;
        RegDst     = RD_RT;
        Mem2Reg    = M2R_ALU;
        RegWrite   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrc2    = SRC2_FOUR;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ok;
                PCWrite    = mem_ok;
            end
            S_DECODE: begin
                ALUSrc2    = SRC2_IMM2;
                ALUControl = ALU_ADD;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrc1    = 1'b1;
                ALUSrc2    = state_q == S_EXEC_R ? SRC2_RT : SRC2_IMM;
                ALUControl = dec_alu;
            end
            S_MEM_ADDR: begin
                ALUSrc1    = 1'b1;
                ALUSrc2    = SRC2_IMM;
                ALUControl = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                Mem2Reg  = M2R_MDR;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = opcode == OP_R ? RD_RD : RD_RT;
            end
            S_BRANCH: begin
                ALUSrc1    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                PCWrite    = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSrc    = opcode == OP_R ? PC_RS : PC_JUMP;
                RegWrite = opcode == OP_JAL;
                RegDst   = opcode == OP_JAL ? RD_RA : RD_RT;
                Mem2Reg  = opcode == OP_JAL ? M2R_PC : M2R_ALU;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

    // active cycles exclude RST/HALT; an instruction retires when a completing state returns to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_RST && state_q != S_HALT)
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (state_d == S_FETCH && state_q != S_RST && state_q != S_FETCH)
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule
